// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbling and
// link-register selection. Optional hazard counters under HAZARD_CNT_EN.
module id_ex_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_Branch,
  input  logic [1:0]       id_Jump,
  input  logic             id_RegDst,
  input  logic             id_ALUSrc,
  input  logic [4:0]       id_ALUOp,
  input  logic             id_MemtoReg,
  input  logic             id_RegWrite,
  input  logic [1:0]       id_MemWrite,
  input  logic             id_ExtOp,
  input  logic [2:0]       id_MemRead,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_rdata1,
  input  logic [31:0]      id_rdata2,
  input  logic [31:0]      id_imm32,
  input  logic [31:0]      id_pc4,
  input  logic             flush,
  output logic             hazard,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [3:0]       ex_Branch,
  output logic [1:0]       ex_Jump,
  output logic             ex_RegDst,
  output logic             ex_ALUSrc,
  output logic [4:0]       ex_ALUOp,
  output logic             ex_MemtoReg,
  output logic             ex_RegWrite,
  output logic [1:0]       ex_MemWrite,
  output logic             ex_ExtOp,
  output logic [2:0]       ex_MemRead,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_rdata1,
  output logic [31:0]      ex_rdata2,
  output logic [31:0]      ex_imm32,
  output logic [31:0]      ex_pc4,
  output logic             ex_valid,
  output logic [4:0]       ex_wreg
`ifdef HAZARD_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef struct packed {
    logic [3:0]  branch;
    logic [1:0]  jump;
    logic        regdst;
    logic        alusrc;
    logic [4:0]  aluop;
    logic        memtoreg;
    logic        regwrite;
    logic [1:0]  memwrite;
    logic        extop;
    logic [2:0]  memread;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm32;
    logic [31:0] pc4;
    logic        valid;
    logic [4:0]  wreg;
  } ex_t;

  typedef enum logic {RUN, STALL} state_t;

  state_t state, state_nxt;
  ex_t    ex_q, id_d, nop;
  logic   load_use;

  always_comb begin
    nop       = '0;
    nop.aluop = 5'b11111;
  end

  always_comb begin
    id_d          = '0;
    id_d.branch   = id_Branch;
    id_d.jump     = id_Jump;
    id_d.regdst   = id_RegDst;
    id_d.alusrc   = id_ALUSrc;
    id_d.aluop    = id_ALUOp;
    id_d.memtoreg = id_MemtoReg;
    id_d.regwrite = id_RegWrite;
    id_d.memwrite = id_MemWrite;
    id_d.extop    = id_ExtOp;
    id_d.memread  = id_MemRead;
    id_d.rs       = id_rs;
    id_d.rt       = id_rt;
    id_d.rd       = id_rd;
    id_d.rdata1   = id_rdata1;
    id_d.rdata2   = id_rdata2;
    id_d.imm32    = id_imm32;
    id_d.pc4      = id_pc4;
    id_d.valid    = 1'b1;
    // jal, bgezal and bltzal all link into $ra
    if (id_Jump == 2'b10 || id_Branch == 4'b0101 || id_Branch == 4'b1000)
      id_d.wreg = 5'd31;
    else if (id_RegDst)
      id_d.wreg = id_rd;
    else
      id_d.wreg = id_rt;
  end

  assign load_use = ex_q.valid && (ex_q.memread != 3'b000) && (ex_q.rt != 5'd0) &&
                    (ex_q.rt == id_rs || ex_q.rt == id_rt);
  // A bubble sits in EX during STALL, so the state gate only reinforces that.
  assign hazard     = load_use && !flush && (state == RUN);
  assign pc_write   = !hazard;
  assign ifid_write = !hazard;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hazard) state_nxt = STALL;
      STALL:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      ex_q  <= nop;
    end else begin
      state <= state_nxt;
      ex_q  <= (flush || hazard) ? nop : id_d;
    end
  end

  assign ex_Branch   = ex_q.branch;
  assign ex_Jump     = ex_q.jump;
  assign ex_RegDst   = ex_q.regdst;
  assign ex_ALUSrc   = ex_q.alusrc;
  assign ex_ALUOp    = ex_q.aluop;
  assign ex_MemtoReg = ex_q.memtoreg;
  assign ex_RegWrite = ex_q.regwrite;
  assign ex_MemWrite = ex_q.memwrite;
  assign ex_ExtOp    = ex_q.extop;
  assign ex_MemRead  = ex_q.memread;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_rdata1   = ex_q.rdata1;
  assign ex_rdata2   = ex_q.rdata2;
  assign ex_imm32    = ex_q.imm32;
  assign ex_pc4      = ex_q.pc4;
  assign ex_valid    = ex_q.valid;
  assign ex_wreg     = ex_q.wreg;

`ifdef HAZARD_CNT_EN
  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush  && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: vectors carry inputs and expected results,
// expected EX bundles go through a scoreboard queue; counter corners when enabled.
module tb_id_ex_stage;

  typedef struct packed {
    logic [3:0]  branch;
    logic [1:0]  jump;
    logic        regdst;
    logic        alusrc;
    logic [4:0]  aluop;
    logic        memtoreg;
    logic        regwrite;
    logic [1:0]  memwrite;
    logic        extop;
    logic [2:0]  memread;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm32;
    logic [31:0] pc4;
  } bundle_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] wreg;
    bundle_t    b;
  } ex_t;

  typedef struct {
    bundle_t    b;
    logic       fl;
    logic       r;
    logic       haz;
    logic       val;
    logic [4:0] w;
  } vec_t;

`ifdef HAZARD_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic clk = 1'b0;
  logic rst, flush;
  bundle_t id_b;
  logic hazard, pc_write, ifid_write;
  logic [3:0] ex_Branch;
  logic [1:0] ex_Jump, ex_MemWrite;
  logic ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_ExtOp, ex_valid;
  logic [4:0] ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_wreg;
  logic [2:0] ex_MemRead;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm32, ex_pc4;
`ifdef HAZARD_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif
  ex_t act;

  int pass = 0, total = 0;
  vec_t vecs[$];
  ex_t  sb[$];

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_Branch(id_b.branch), .id_Jump(id_b.jump), .id_RegDst(id_b.regdst),
    .id_ALUSrc(id_b.alusrc), .id_ALUOp(id_b.aluop), .id_MemtoReg(id_b.memtoreg),
    .id_RegWrite(id_b.regwrite), .id_MemWrite(id_b.memwrite), .id_ExtOp(id_b.extop),
    .id_MemRead(id_b.memread), .id_rs(id_b.rs), .id_rt(id_b.rt), .id_rd(id_b.rd),
    .id_rdata1(id_b.rdata1), .id_rdata2(id_b.rdata2), .id_imm32(id_b.imm32),
    .id_pc4(id_b.pc4), .flush(flush),
    .hazard(hazard), .pc_write(pc_write), .ifid_write(ifid_write),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_RegDst(ex_RegDst),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_ExtOp(ex_ExtOp),
    .ex_MemRead(ex_MemRead), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm32(ex_imm32),
    .ex_pc4(ex_pc4), .ex_valid(ex_valid), .ex_wreg(ex_wreg)
`ifdef HAZARD_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  assign act = {ex_valid, ex_wreg, ex_Branch, ex_Jump, ex_RegDst, ex_ALUSrc, ex_ALUOp,
                ex_MemtoReg, ex_RegWrite, ex_MemWrite, ex_ExtOp, ex_MemRead, ex_rs,
                ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm32, ex_pc4};

  task automatic chk(string nm, logic [199:0] a, logic [199:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", nm, a, e);
    else pass++;
  endtask

  function automatic bundle_t base();
    bundle_t b = '0;
    b.rdata1 = $urandom; b.rdata2 = $urandom;
    b.imm32  = $urandom; b.pc4    = $urandom;
    return b;
  endfunction

  function automatic bundle_t rnd();
    bundle_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  function automatic bundle_t addi(logic [4:0] rt, logic [31:0] imm);
    bundle_t b = base();
    b.alusrc = 1; b.regwrite = 1; b.extop = 1; b.rt = rt; b.rd = 5'd21; b.imm32 = imm;
    return b;
  endfunction

  function automatic bundle_t lw(logic [4:0] rt, logic [4:0] rs, logic [2:0] mr);
    bundle_t b = base();
    b.alusrc = 1; b.memtoreg = 1; b.regwrite = 1; b.extop = 1; b.memread = mr;
    b.rs = rs; b.rt = rt; b.rd = 5'd22;
    return b;
  endfunction

  function automatic bundle_t rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    bundle_t b = base();
    b.regdst = 1; b.regwrite = 1; b.aluop = 5'd2; b.rs = rs; b.rt = rt; b.rd = rd;
    return b;
  endfunction

  function automatic bundle_t link(logic [3:0] br, logic [1:0] jp, logic [4:0] rt);
    bundle_t b = base();
    b.branch = br; b.jump = jp; b.regwrite = 1; b.regdst = 1; b.rt = rt; b.rd = 5'd17;
    return b;
  endfunction

  function automatic vec_t v(bundle_t b, logic fl, logic r, logic haz, logic val, logic [4:0] w);
    vec_t x;
    x.b = b; x.fl = fl; x.r = r; x.haz = haz; x.val = val; x.w = w;
    return x;
  endfunction

  function automatic ex_t nop_ex();
    ex_t e = '0;
    e.b.aluop = 5'b11111;
    return e;
  endfunction

  task automatic step(bundle_t b, logic fl, logic r);
    @(negedge clk);
    id_b = b; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ex_t e, got;
    rst = 1; flush = 0; id_b = '0;

    //            inputs                          flush rst haz val wreg
    vecs.push_back(v(rnd(),                         0, 1, 0, 0, 5'd0));
    vecs.push_back(v(rnd(),                         0, 1, 0, 0, 5'd0));
    vecs.push_back(v(addi(5'd8, 32'h5),             0, 0, 0, 1, 5'd8));
    vecs.push_back(v(lw(5'd9, 5'd3, 3'b001),        0, 0, 0, 1, 5'd9));
    vecs.push_back(v(rtype(5'd9, 5'd4, 5'd10),      0, 0, 1, 0, 5'd0));
    vecs.push_back(v(rtype(5'd9, 5'd4, 5'd10),      0, 0, 0, 1, 5'd10));
    vecs.push_back(v(lw(5'd9, 5'd2, 3'b001),        0, 0, 0, 1, 5'd9));
    vecs.push_back(v(rtype(5'd5, 5'd9, 5'd11),      1, 0, 0, 0, 5'd0));
    vecs.push_back(v(rtype(5'd9, 5'd1, 5'd12),      0, 0, 0, 1, 5'd12));
    vecs.push_back(v(lw(5'd0, 5'd1, 3'b001),        0, 0, 0, 1, 5'd0));
    vecs.push_back(v(rtype(5'd0, 5'd0, 5'd13),      0, 0, 0, 1, 5'd13));
    vecs.push_back(v(link(4'b0000, 2'b10, 5'd0),    0, 0, 0, 1, 5'd31));
    vecs.push_back(v(link(4'b0101, 2'b00, 5'd1),    0, 0, 0, 1, 5'd31));
    vecs.push_back(v(link(4'b1000, 2'b00, 5'd0),    0, 0, 0, 1, 5'd31));
    vecs.push_back(v(lw(5'd7, 5'd0, 3'b100),        0, 0, 0, 1, 5'd7));
    vecs.push_back(v(rtype(5'd1, 5'd7, 5'd3),       0, 0, 1, 0, 5'd0));
    vecs.push_back(v(rtype(5'd1, 5'd7, 5'd3),       0, 1, 0, 0, 5'd0));
    vecs.push_back(v(lw(5'd6, 5'd0, 3'b001),        0, 0, 0, 1, 5'd6));
    vecs.push_back(v(rtype(5'd6, 5'd2, 5'd4),       0, 1, 1, 0, 5'd0));
    vecs.push_back(v(rtype(5'd6, 5'd2, 5'd4),       0, 0, 0, 1, 5'd4));
    vecs.push_back(v(addi(5'd6, 32'hffff_fff0),     0, 0, 0, 1, 5'd6));
    vecs.push_back(v(rtype(5'd6, 5'd3, 5'd5),       0, 0, 0, 1, 5'd5));

    foreach (vecs[i]) begin
      @(negedge clk);
      id_b = vecs[i].b; flush = vecs[i].fl; rst = vecs[i].r;
      #1;
      // EX register is undefined before the first reset edge
      if (i > 0)
        chk($sformatf("vec%0d hazard/pc_write/ifid_write", i),
            {hazard, pc_write, ifid_write},
            {vecs[i].haz, !vecs[i].haz, !vecs[i].haz});
      if (vecs[i].val) begin
        e.valid = 1'b1; e.wreg = vecs[i].w; e.b = vecs[i].b;
      end else e = nop_ex();
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk($sformatf("vec%0d ex bundle", i), act, got);
    end

`ifdef HAZARD_CNT_EN
    step(rnd(), 0, 1);
    chk("cnt reset", {stall_cnt, flush_cnt}, '0);
    step(lw(5'd9, 5'd0, 3'b001), 0, 0);
    step(rtype(5'd0, 5'd9, 5'd8), 1, 0);
    chk("flush beats load-use stall_cnt", stall_cnt, 4'd0);
    chk("flush beats load-use flush_cnt", flush_cnt, 4'd1);
    step(lw(5'd9, 5'd0, 3'b001), 0, 0);
    step(rtype(5'd9, 5'd0, 5'd8), 0, 0);
    chk("stall_cnt after load-use", stall_cnt, 4'd1);
    step(rtype(5'd9, 5'd0, 5'd8), 0, 0);
    chk("stall_cnt one-cycle stall", stall_cnt, 4'd1);
    for (int k = 0; k < 20; k++) step(rtype(5'd1, 5'd2, 5'd3), 1, 0);
    chk("flush_cnt saturated", flush_cnt, 4'd15);
    step(rtype(5'd1, 5'd2, 5'd3), 1, 0);
    chk("flush_cnt holds", flush_cnt, 4'd15);
    step(rnd(), 0, 1);
    chk("cnt cleared by rst", {stall_cnt, flush_cnt}, '0);
`endif

    if (sb.size() != 0) chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the hazard statistics counters.
REQ-002 SHALL have ports clk input 1 (rising-edge clock) and rst input 1; one clock; reset is synchronous and active-high.
REQ-003 SHALL have id_Branch in 4, id_Jump in 2, id_RegDst in 1, id_ALUSrc in 1, id_ALUOp in 5, id_MemtoReg in 1, id_RegWrite in 1, id_MemWrite in 2, id_ExtOp in 1, id_MemRead in 3: decoder control bundle for the ID instruction.
REQ-004 SHALL have id_rs, id_rt, id_rd in 5 each and id_rdata1, id_rdata2, id_imm32, id_pc4 in 32 each: ID operands, extended immediate and PC+4.
REQ-005 SHALL have flush in 1: taken branch or jump resolved downstream; kill the ID instruction.
REQ-006 SHALL have hazard out 1 (to decoder, forces the nop bundle), pc_write out 1 and ifid_write out 1 (enables for PC and IF/ID).
REQ-007 SHALL have ex_<field> outputs with the same widths as each REQ-003/004 field, plus ex_valid out 1 and ex_wreg out 5.
REQ-008 SHALL have stall_cnt and flush_cnt outputs, CNT_W each, present only per REQ-020.

Function
REQ-009 Nop bundle SHALL be all control fields 0 except ALUOp = 5'b11111, with all data fields 0 and ex_valid = 0.
REQ-010 load_use SHALL be ex_valid & (ex_MemRead != 3'b000) & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
REQ-011 hazard SHALL be combinational: load_use & ~flush.
REQ-012 pc_write and ifid_write SHALL both equal ~hazard, combinationally.
REQ-013 Every rising clk SHALL apply the first matching rule: rst, then flush, then hazard each load the nop bundle; otherwise latch all id_* fields with ex_valid = 1.
REQ-014 The mux result SHALL be registered as ex_wreg: 31 when id_Jump = 2'b10 (jal) or id_Branch is 4'b0101 or 4'b1000 (bgezal, bltzal); id_rd when id_RegDst = 1; id_rt otherwise.
REQ-015 Latency SHALL be one cycle from ID inputs to ex_* outputs, with no combinational path from id_* to ex_*.
REQ-016 The block SHALL have a two-state FSM. RUN goes to STALL when hazard = 1. STALL goes to RUN unconditionally. Reset enters RUN.
REQ-017 In STALL, hazard SHALL be 0 because a bubble occupies EX, so each load-use stall lasts exactly one cycle.
REQ-018 When flush and load_use are both 1, flush SHALL win: hazard = 0, pc_write = 1, bubble inserted, FSM stays RUN.

Reset
REQ-019 When rst = 1 at a clock edge, the block SHALL set all ex_* to the nop bundle, ex_wreg = 0, the FSM to RUN and the counters to 0. This applies mid-stall, and the pending stall is abandoned.

Configuration
REQ-020 With HAZARD_CNT_EN defined, the block SHALL implement stall_cnt (+1 per cycle with hazard = 1) and flush_cnt (+1 per cycle with flush = 1), each saturating at all-ones and cleared by rst.
REQ-021 Without HAZARD_CNT_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-022 Reset: rst = 1 for 2 cycles with random id_* -> ex_ALUOp = 5'b11111, ex_valid = 0, all other ex_* = 0, hazard = 0.
REQ-023 Pass-through: addi bundle, id_rt = 8, id_imm32 = 32'h00000005 -> next cycle ex_ALUSrc = 1, ex_RegWrite = 1, ex_wreg = 8, ex_imm32 = 5, ex_valid = 1.
REQ-024 Load-use: lw to rt = 9 latched, then id_rs = 9 -> hazard = 1 and pc_write = 0 for exactly 1 cycle; next ex_valid = 0; the following cycle latches the dependent instruction.
REQ-025 Simultaneous events: lw rt = 9 in EX, id_rt = 9 and flush = 1 -> hazard = 0, pc_write = 1, bubble latched; with HAZARD_CNT_EN, flush_cnt +1 and stall_cnt unchanged.
REQ-026 Link and corner cases: jal latched -> ex_wreg = 31. lw to rt = 0 followed by id_rs = 0 -> hazard = 0.
REQ-027 Saturation: with HAZARD_CNT_EN and CNT_W = 4, hold flush = 1 for 20 cycles -> flush_cnt = 15 and holds there.
